// File: rtl/depth_fifo.sv
// depth_fifo: single-clock first-word-fall-through FIFO.
// Full/non-empty status; writes are dropped while full.
module depth_fifo #(
   parameter int p_depth     = 8,
   parameter int p_word_size = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [p_word_size-1:0] data_i,
   input  logic                   write_enable_i,
   input  logic                   read_enable_i,
   output logic [p_word_size-1:0] data_o,
   output logic                   read_valid_o,
   output logic                   full_o
);

   localparam int c_aw = $clog2(p_depth);
   localparam int c_cw = $clog2(p_depth + 1);
   localparam logic [c_aw-1:0] c_last = c_aw'(p_depth - 1);
   localparam logic [c_cw-1:0] c_full = c_cw'(p_depth);

   logic [p_word_size-1:0] r_mem [p_depth];
   logic [c_aw-1:0]        r_wr_ptr;
   logic [c_aw-1:0]        r_rd_ptr;
   logic [c_cw-1:0]        r_count;

   logic w_full;
   logic w_valid;
   logic w_wr_acc;
   logic w_rd_acc;

   // Acceptance uses pre-edge flags: a write while full is dropped
   // even if a read frees a slot on the same edge.
   assign w_full   = (r_count == c_full);
   assign w_valid  = (r_count != '0);
   assign w_wr_acc = write_enable_i && !w_full;
   assign w_rd_acc = read_enable_i && w_valid;

   assign data_o       = r_mem[r_rd_ptr];
   assign read_valid_o = w_valid;
   assign full_o       = w_full;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < p_depth; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
      end else if (w_wr_acc) begin
         if (r_wr_ptr == c_last) begin
            r_wr_ptr <= '0;
         end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rd_ptr <= '0;
      end else if (w_rd_acc) begin
         if (r_rd_ptr == c_last) begin
            r_rd_ptr <= '0;
         end else begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_count <= '0;
      end else begin
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_depth_fifo.sv
// tb_depth_fifo: directed scoreboard bench for depth_fifo.
// Expected words are queued on accepted writes, checked on pops.
module tb_depth_fifo;

   localparam int c_depth = 8;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic [7:0] data_i = '0;
   logic       write_enable_i = 1'b0;
   logic       read_enable_i = 1'b0;
   logic [7:0] data_o;
   logic       read_valid_o;
   logic       full_o;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] sb_q [$];

   localparam logic [7:0] c_a = 8'hA1;
   localparam logic [7:0] c_b = 8'hB2;
   localparam logic [7:0] c_c = 8'hC3;

   depth_fifo #(.p_depth(c_depth), .p_word_size(8)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .data_i         (data_i),
      .write_enable_i (write_enable_i),
      .read_enable_i  (read_enable_i),
      .data_o         (data_o),
      .read_valid_o   (read_valid_o),
      .full_o         (full_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic flags(input string tag);
      check({tag, " valid"}, {7'd0, read_valid_o},
            {7'd0, sb_q.size() != 0});
      check({tag, " full"}, {7'd0, full_o},
            {7'd0, sb_q.size() == c_depth});
      if (sb_q.size() != 0) check({tag, " head"}, data_o, sb_q[0]);
   endtask

   // Called just after a falling edge; returns after the next one.
   task automatic cyc(input string tag, input logic we,
                      input logic re, input logic [7:0] d);
      bit m_full;
      bit m_valid;
      m_full  = (sb_q.size() == c_depth);
      m_valid = (sb_q.size() != 0);
      write_enable_i = we;
      read_enable_i  = re;
      data_i         = d;
      #1;
      if (re && m_valid) begin
         check({tag, " pop"}, data_o, sb_q[0]);
         void'(sb_q.pop_front());
      end
      if (we && !m_full) sb_q.push_back(d);
      @(posedge clk_i);
      #1;
      write_enable_i = 1'b0;
      read_enable_i  = 1'b0;
      flags(tag);
      @(negedge clk_i);
   endtask

   initial begin
      repeat (5) @(posedge clk_i);
      #1;
      check("rst valid", {7'd0, read_valid_o}, 8'd0);
      check("rst full", {7'd0, full_o}, 8'd0);
      check("rst data", data_o, 8'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      cyc("wr A", 1, 0, c_a);
      cyc("wr B", 1, 0, c_b);
      cyc("wr C", 1, 0, c_c);
      cyc("rd A", 0, 1, 8'h00);
      cyc("rd B", 0, 1, 8'h00);
      for (int i = 0; i < 6; i++) cyc("wr six", 1, 0, 8'h11 + 8'(i));
      cyc("wr E", 1, 0, 8'hEE);
      check("full after E", {7'd0, full_o}, 8'd1);
      cyc("wr F drop", 1, 0, 8'hFF);
      cyc("rd from full", 0, 1, 8'h00);
      check("full fell", {7'd0, full_o}, 8'd0);
      while (sb_q.size() != 0) cyc("drain", 0, 1, 8'h00);
      check("stale valid", {7'd0, read_valid_o}, 8'd0);
      check("stale data", data_o, c_c);

      cyc("rd empty", 0, 1, 8'h00);
      check("rd empty data", data_o, c_c);

      for (int i = 0; i < c_depth; i++) cyc("fill", 1, 0, 8'h20 + 8'(i));
      check("filled", {7'd0, full_o}, 8'd1);
      cyc("rw full", 1, 1, 8'h30);
      check("rw full flag", {7'd0, full_o}, 8'd0);
      while (sb_q.size() != 0) cyc("drain2", 0, 1, 8'h00);

      cyc("wr one", 1, 0, 8'h40);
      cyc("rw one", 1, 1, 8'h41);
      check("rw one data", data_o, 8'h41);
      cyc("rd last", 0, 1, 8'h00);
      cyc("rw empty", 1, 1, 8'h55);
      check("rw empty data", data_o, 8'h55);
      cyc("rd 55", 0, 1, 8'h00);

      for (int i = 0; i < 4; i++) cyc("wr four", 1, 0, 8'h60 + 8'(i));
      #2;
      rst_n_i = 1'b0;
      #1;
      check("arst valid", {7'd0, read_valid_o}, 8'd0);
      check("arst data", data_o, 8'd0);
      check("arst full", {7'd0, full_o}, 8'd0);
      sb_q.delete();
      @(negedge clk_i);
      rst_n_i = 1'b1;
      cyc("post rst wr", 1, 0, 8'h77);
      cyc("post rst rd", 0, 1, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/depth_fifo.md
# depth_fifo

Synchronous single-clock FIFO of `p_depth` words of `p_word_size` bits, used as the TX/RX data buffer between the UART shift logic and its host-side interface. The head entry is shown on `data_o` combinationally (first-word-fall-through), so a consumer samples `data_o` and pulses `read_enable_i` to pop it. The block reports full/non-empty status and silently drops writes when it is full.

## Interface
- `p_depth`, default 8: number of storage words; must be ≥ 2, and need not be a power of two.
- `p_word_size`, default 8: word width in bits.

Ports:
- `clk_i`  in  1  clock; all state updates occur on the rising edge.
- `rst_n_i`  in  1  reset; one clock, reset asynchronous and active-low.
- `data_i`  in  p_word_size  write data.
- `write_enable_i`  in  1  push `data_i` on this edge.
- `read_enable_i`  in  1  pop the head entry on this edge.
- `data_o`  out  p_word_size  `mem[rd_ptr]`, driven combinationally.
- `read_valid_o`  out  1  FIFO not empty (count ≠ 0).
- `full_o`  out  1  FIFO full (count == p_depth).

## Operation
- State:
  - `mem[p_depth]`;
  - `wr_ptr` and `rd_ptr`, each `$clog2(p_depth)` bits;
  - `count`, `$clog2(p_depth+1)` bits.
- Reset (asserted low):
  - `wr_ptr`, `rd_ptr` and `count` are cleared to 0;
  - all `mem` words are cleared to 0;
  - outputs during and after reset: `data_o`=0, `read_valid_o`=0, `full_o`=0.
- Write accepted when `write_enable_i && !full_o`:
  - `mem[wr_ptr] <= data_i`;
  - `wr_ptr` increments, wrapping from p_depth-1 to 0.
- A write while `full_o`=1 is dropped, with no change to any state.
- Read accepted when `read_enable_i && read_valid_o`:
  - `rd_ptr` increments with the same wrap rule;
  - memory is not modified.
- A read while empty is ignored, and the pointers stay put.
- `count` update rule:
  - +1 on accepted write only;
  - −1 on accepted read only;
  - unchanged when both are accepted or neither is.
- Simultaneous read and write:
  - Non-empty and non-full: both are accepted.
  - Full: the read is accepted and the write is dropped, because acceptance is decided on pre-edge flags.
  - Empty: the write is accepted and the read is ignored.
- `data_o` is always `mem[rd_ptr]`, including when empty. Once the FIFO has drained, `data_o` shows the stale word at `rd_ptr` (wrapped-around old data), and `read_valid_o` flags it invalid.
- All `p_depth` slots are usable.

## Timing
- Write latency: data written on edge N is visible on `data_o` right after edge N if the FIFO was empty. If the FIFO was not empty, `data_o` keeps the current head.
- Pop latency: after a read accepted on edge N, `data_o` shows the next entry immediately after edge N, with zero-cycle combinational lookup.
- Flags are registered-state decodes of `count` and update right after the edge that changes `count`:
  - `full_o` rises after the p_depth-th unread write;
  - `full_o` falls after the first accepted read from full;
  - `read_valid_o` falls after the last entry is popped.
- Asynchronous reset asserted mid-operation clears state immediately, without waiting for a clock edge. Contents are lost.
- No combinational path from `data_i`/enables to any output.

## Test plan
- Reset, then fill:
  - Hold `rst_n_i`=0 for 5 cycles → `read_valid_o`=0, `full_o`=0, `data_o`=0.
  - Release and write A, B, C → `data_o`=A after each write and `read_valid_o`=1.
- FWFT pop:
  - With A, B, C queued, read: `data_o`=A before the edge and B after it.
  - Read again → `data_o`=C.
  - Then write 6 words → `data_o` stays C and `full_o`=0 (7 entries).
- Full and drop:
  - Write an 8th word E → `full_o`=1.
  - Write F → dropped, `full_o` stays 1, count stays 8.
  - Read one word → `full_o`=0.
- Drain with wrap:
  - Read the remaining entries → they come out in exact write order, ending with E; F never appears.
  - After the last pop, `read_valid_o`=0 and `data_o` equals the stale word at the wrapped `rd_ptr` (C in the sequence above).
- Empty/full corner handshakes:
  - Read on empty → no pointer change.
  - Simultaneous read+write when full → one pop, write dropped, `full_o`=0 afterwards.
  - Simultaneous read+write with 1 entry → count unchanged and `data_o` = new word.
- Async reset mid-stream:
  - Drop `rst_n_i` between clock edges with 4 entries queued → `read_valid_o`=0 and `data_o`=0 immediately.
